bitscan_seq: RTL and testbench

- Sequencer around the lowest-set-bit datapath (1-based index of the lowest 1 in a 32-bit word; 0 means the word is zero).
- On a start pulse it captures a 32-bit mask and emits the index of every set bit, lowest first, one per accepted handshake.
- Each emitted bit is cleared with mask & (mask-1).
- Drives multi-register / bitmap-walk sequencing in the P5 pipeline (e.g. register-list or pending-source scans).

---
 rtl/bitscan_seq.sv | 120 ++++++++++++
 tb/tb_bitscan_seq.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/bitscan_seq.sv
// Bitmap-walk sequencer: captures a mask on start and emits the 1-based index
// of every set bit, lowest first, one per accepted valid/ready handshake.
// Each emitted bit is cleared with mask & (mask - 1). A zero mask produces no
// indices and finishes straight away.

module bitscan_seq #(
    parameter int unsigned DW = 32,
    parameter int unsigned IW = 6
) (
    input  logic          clk_i,
    input  logic          reset_ni,
    input  logic          start_i,
    input  logic [DW-1:0] din_i,
    input  logic          abort_i,
    output logic          busy_o,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [IW-1:0] out_idx_o,
    output logic          out_last_o,
    output logic          done_o,
    output logic [IW-1:0] count_o
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StScan = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [DW-1:0] mask_q, mask_d;
    logic [IW-1:0] count_q, count_d;

    logic [DW-1:0] mask_clr;
    logic [IW-1:0] low_idx;
    logic          is_last;
    logic          in_scan;
    logic          hshake;

    // 1-based index of the lowest set bit; 0 for a zero word.
    function automatic logic [IW-1:0] lowbit(input logic [DW-1:0] m);
        logic [IW-1:0] r;
        r = '0;
        // Scan downwards so the lowest set bit is the final assignment.
        for (int k = DW - 1; k >= 0; k--) begin
            if (m[k]) begin
                r = IW'(k + 1);
            end
        end
        return r;
    endfunction

    // Datapath terms derived from the working mask.
    always_comb begin
        mask_clr = mask_q & (mask_q - DW'(1));
        low_idx  = lowbit(mask_q);
        is_last  = (mask_clr == '0);
        in_scan  = (state_q == StScan);
        hshake   = in_scan && out_ready_i;
    end

    // Next-state logic for state, mask and accepted-index count.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        count_d = count_q;
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    mask_d  = din_i;
                    count_d = '0;
                    state_d = (din_i != '0) ? StScan : StDone;
                end
            end
            StScan: begin
                if (hshake) begin
                    mask_d  = mask_clr;
                    count_d = count_q + IW'(1);
                    if (is_last) begin
                        state_d = StDone;
                    end
                end
                // Abort wins over continuing, but a same-cycle handshake still counts.
                if (abort_i) begin
                    mask_d  = '0;
                    state_d = StDone;
                end
            end
            StDone: begin
                // start here is deliberately ignored; it must arrive in idle.
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q <= StIdle;
            mask_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            count_q <= count_d;
        end
    end

    // Outputs decoded from the registered state; index outputs gated to 0 when not valid.
    always_comb begin
        busy_o      = (state_q == StScan) || (state_q == StDone);
        out_valid_o = in_scan;
        out_idx_o   = in_scan ? low_idx : '0;
        out_last_o  = in_scan && is_last;
        done_o      = (state_q == StDone);
        count_o     = count_q;
    end

endmodule

// File: tb/tb_bitscan_seq.sv
// Directed testbench for bitscan_seq with hand-computed expectations.

module tb_bitscan_seq;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [31:0] din;
    logic        abort;
    logic        busy;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_idx;
    logic        out_last;
    logic        done;
    logic [5:0]  count;

    int n_tests = 0;
    int n_fail  = 0;

    bitscan_seq #(
        .DW(32),
        .IW(6)
    ) u_dut (
        .clk_i       (clk),
        .reset_ni    (reset_n),
        .start_i     (start),
        .din_i       (din),
        .abort_i     (abort),
        .busy_o      (busy),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_idx_o   (out_idx),
        .out_last_o  (out_last),
        .done_o      (done),
        .count_o     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_valid(input string tag, input int idx, input bit last);
        check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
        check_eq({tag, "_idx"}, 32'(out_idx), 32'(idx));
        check_eq({tag, "_last"}, 32'(out_last), 32'(last));
    endtask

    task automatic chk_done(input string tag, input int cnt);
        check_eq({tag, "_done"}, 32'(done), 32'd1);
        check_eq({tag, "_busy"}, 32'(busy), 32'd1);
        check_eq({tag, "_valid"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_idx0"}, 32'(out_idx), 32'd0);
        check_eq({tag, "_count"}, 32'(count), 32'(cnt));
    endtask

    task automatic chk_idle(input string tag, input int cnt);
        check_eq({tag, "_done"}, 32'(done), 32'd0);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_valid"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_idx0"}, 32'(out_idx), 32'd0);
        check_eq({tag, "_last0"}, 32'(out_last), 32'd0);
        check_eq({tag, "_count"}, 32'(count), 32'(cnt));
    endtask

    task automatic do_start(input logic [31:0] mask);
        din   = mask;
        start = 1'b1;
        step();
        start = 1'b0;
        din   = 32'hDEAD_BEEF;
    endtask

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        din       = '0;
        abort     = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        chk_idle("reset", 0);
        reset_n = 1'b1;
        step();

        // Basic scan: bits 0, 4, 31.
        out_ready = 1'b1;
        do_start(32'h8000_0011);
        chk_valid("basic_c1", 1, 1'b0);
        check_eq("basic_c1_busy", 32'(busy), 32'd1);
        step();
        chk_valid("basic_c2", 5, 1'b0);
        step();
        chk_valid("basic_c3", 32, 1'b1);
        check_eq("basic_c3_count", 32'(count), 32'd2);
        step();
        chk_done("basic_end", 3);
        step();
        chk_idle("basic_idle", 3);

        // Zero mask goes straight to done.
        do_start(32'h0);
        chk_done("zero", 0);
        step();
        chk_idle("zero_idle", 0);

        // Backpressure: index held while ready is low.
        out_ready = 1'b0;
        do_start(32'h0000_0006);
        for (int i = 0; i < 5; i++) begin
            chk_valid("bp_hold", 2, 1'b0);
            check_eq("bp_hold_count", 32'(count), 32'd0);
            step();
        end
        out_ready = 1'b1;
        chk_valid("bp_r1", 2, 1'b0);
        step();
        chk_valid("bp_r2", 3, 1'b1);
        step();
        chk_done("bp_end", 2);
        step();
        chk_idle("bp_idle", 2);

        // Full mask with an ignored start mid-scan and during done.
        do_start(32'hFFFF_FFFF);
        for (int i = 1; i <= 32; i++) begin
            chk_valid("full", i, (i == 32));
            start = (i == 10);
            din   = 32'h1;
            step();
        end
        start = 1'b0;
        chk_done("full_end", 32);
        start = 1'b1;
        din   = 32'h1;
        step();
        start = 1'b0;
        chk_idle("full_idle", 32);
        step();
        chk_idle("full_idle2", 32);

        // Abort on the second valid cycle together with a handshake.
        do_start(32'h0000_00F0);
        chk_valid("abort_c1", 5, 1'b0);
        step();
        chk_valid("abort_c2", 6, 1'b0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk_done("abort_end", 2);
        step();
        chk_idle("abort_idle", 2);

        // Abort without a handshake delivers nothing.
        out_ready = 1'b0;
        do_start(32'h0000_00F0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk_done("abort_nr_end", 0);
        step();
        chk_idle("abort_nr_idle", 0);

        // Abort in idle is ignored.
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk_idle("abort_in_idle", 0);

        // Reset mid-scan discards the scan without a done pulse.
        out_ready = 1'b1;
        do_start(32'h0000_0005);
        chk_valid("rst_c1", 1, 1'b0);
        step();
        chk_valid("rst_c2", 3, 1'b1);
        check_eq("rst_c2_count", 32'(count), 32'd1);
        reset_n = 1'b0;
        step();
        chk_idle("rst_after", 0);
        reset_n = 1'b1;
        step();
        chk_idle("rst_nodone", 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
